// File: rtl/logic_gate_unit.sv
// Bitwise logic unit: one operation per accepted input, results queued in a
// 2-entry FIFO and counted as the consumer takes them.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] C,
  output logic             C_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid are pure functions of occupancy, never of the peer.
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [WIDTH-1:0] result;
  logic             push;
  logic             pop;

  always_comb begin
    result = A;
    case (mode)
      3'b000:  result = A & B;
      3'b001:  result = A | B;
      3'b010:  result = A ^ B;
      3'b011:  result = ~(A & B);
      3'b100:  result = ~(A | B);
      3'b101:  result = ~(A ^ B);
      3'b110:  result = ~A;
      default: result = A;
    endcase
  end

  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    op_count_d = op_count_q;
    if (push) begin
      mem_d[wr_ptr_q] = result;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      op_count_d = op_count_q + CNT_W'(1);
    end
    if (push && !pop)
      occ_d = occ_q + 2'd1;
    else if (pop && !push)
      occ_d = occ_q - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      op_count_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      op_count_q <= op_count_d;
    end
  end

  // Output is forced to zero while empty so stale entries never leak out.
  assign C        = out_valid ? mem_q[rd_ptr_q] : '0;
  assign C_zero   = out_valid && (mem_q[rd_ptr_q] == '0);
  assign op_count = op_count_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: an 8-bit/4-bit-counter instance and a 1-bit
// instance, with a scoreboard queue per instance.
module tb_logic_gate_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a, b, c;
  logic [2:0]  mode;
  logic        in_valid, in_ready, out_valid, out_ready, c_zero;
  logic [3:0]  op_count;

  logic [0:0]  a1, b1, c1;
  logic [2:0]  mode1;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, c_zero1;
  logic [15:0] op_count1;

  logic_gate_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .C(c), .C_zero(c_zero), .out_valid(out_valid),
    .out_ready(out_ready), .op_count(op_count)
  );

  logic_gate_unit #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .mode(mode1), .in_valid(in_valid1),
    .in_ready(in_ready1), .C(c1), .C_zero(c_zero1), .out_valid(out_valid1),
    .out_ready(out_ready1), .op_count(op_count1)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [0:0] exp1_q[$];
  logic [7:0] sb_e;
  logic [0:0] sb_e1;
  logic [3:0] exp_cnt = 4'd0;

  function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic [2:0] m);
    case (m)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  // Scoreboard: decide at the negedge which transfers the next edge will do.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got C=%0h with nothing expected", c);
        end else begin
          sb_e = exp_q.pop_front();
          if (c !== sb_e) begin
            errors++;
            $display("FAIL sb_order: got C=%0h expected %0h", c, sb_e);
          end
        end
        exp_cnt = exp_cnt + 4'd1;
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, mode));
      if (out_valid1 && out_ready1) begin
        checks++;
        if (exp1_q.size() == 0) begin
          errors++;
          $display("FAIL sb1_underflow: got C=%0h with nothing expected", c1);
        end else begin
          sb_e1 = exp1_q.pop_front();
          if (c1 !== sb_e1) begin
            errors++;
            $display("FAIL sb1_order: got C=%0h expected %0h", c1, sb_e1);
          end
        end
      end
      if (in_valid1 && in_ready1) begin
        sb_e = model({7'b0, a1}, {7'b0, b1}, mode1);
        exp1_q.push_back(sb_e[0]);
      end
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b1;
    a = 8'hA5; b = 8'h5A; mode = 3'd1; in_valid = 1'b1; out_ready = 1'b1;
    a1 = 1'b1; b1 = 1'b1; mode1 = 3'd0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || c !== 8'h00 || c_zero !== 1'b0 || op_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: got ov=%b ir=%b C=%0h cz=%b cnt=%0d expected 0 1 0 0 0",
               out_valid, in_ready, c, c_zero, op_count);
    end
    wait_cycle();
    wait_cycle();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 4'd0 || out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got ov=%b ir=%b cnt=%0d ov1=%b expected 0 1 0 0",
               out_valid, in_ready, op_count, out_valid1);
    end
    // Release with an operation already waiting: the very next edge takes it.
    rst = 1'b0;
    a = 8'h3C; b = 8'h0F; mode = 3'd2; out_ready = 1'b0;
    e = 8'h33;
    wait_cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || c !== e) begin
      errors++;
      $display("FAIL first_accept: got ov=%b C=%0h expected 1 %0h", out_valid, c, e);
    end
    out_ready = 1'b1;
    wait_cycle();
    checks++;
    if (out_valid !== 1'b0 || c !== 8'h00 || c_zero !== 1'b0) begin
      errors++;
      $display("FAIL empty_zero: got ov=%b C=%0h cz=%b expected 0 0 0", out_valid, c, c_zero);
    end
  endtask

  task automatic test_truth_table();
    logic [3:0] tt [8];
    tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b1100};
    out_ready1 = 1'b1;
    for (int m = 0; m < 8; m++) begin
      for (int p = 0; p < 4; p++) begin
        a1 = p[1]; b1 = p[0]; mode1 = m[2:0]; in_valid1 = 1'b1;
        wait_cycle();
        checks++;
        if (out_valid1 !== 1'b1 || c1 !== tt[m][p]) begin
          errors++;
          $display("FAIL truth_m%0d_a%0d_b%0d: got ov=%b C=%b expected 1 %b",
                   m, p[1], p[0], out_valid1, c1, tt[m][p]);
        end
      end
    end
    in_valid1 = 1'b0;
    wait_cycle();
    checks++;
    if (out_valid1 !== 1'b0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL truth_drain: got ov=%b left=%0d expected 0 0", out_valid1, exp1_q.size());
    end
  endtask

  task automatic test_width();
    logic [26:0] vec [10];
    vec = '{{8'hF0, 8'h3C, 3'd0, 8'h30}, {8'hF0, 8'h3C, 3'd1, 8'hFC},
            {8'hF0, 8'h3C, 3'd2, 8'hCC}, {8'hF0, 8'h3C, 3'd6, 8'h0F},
            {8'h0F, 8'hF0, 3'd0, 8'h00}, {8'hF0, 8'h3C, 3'd3, 8'hCF},
            {8'hF0, 8'h3C, 3'd4, 8'h03}, {8'hF0, 8'h3C, 3'd5, 8'h33},
            {8'hF0, 8'h3C, 3'd7, 8'hF0}, {8'h0F, 8'hF0, 3'd4, 8'h00}};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      {a, b, mode} = vec[i][26:8];
      in_valid = 1'b1;
      wait_cycle();
      checks++;
      if (c !== vec[i][7:0] || c_zero !== (vec[i][7:0] == 8'h00)) begin
        errors++;
        $display("FAIL width_%0d: got C=%0h cz=%b expected %0h %b",
                 i, c, c_zero, vec[i][7:0], vec[i][7:0] == 8'h00);
      end
    end
    in_valid = 1'b0;
    wait_cycle();
  endtask

  task automatic test_backpressure();
    logic [7:0] r [3];
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      mode = 3'($urandom_range(0, 7)); in_valid = 1'b1;
      r[i] = model(a, b, mode);
      if (i < 2) wait_cycle();
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || c !== r[0]) begin
      errors++;
      $display("FAIL bp_full: got ir=%b ov=%b C=%0h expected 0 1 %0h", in_ready, out_valid, c, r[0]);
    end
    wait_cycle();
    checks++;
    if (in_ready !== 1'b0 || c !== r[0]) begin
      errors++;
      $display("FAIL bp_hold: got ir=%b C=%0h expected 0 %0h", in_ready, c, r[0]);
    end
    out_ready = 1'b1;
    wait_cycle();
    checks++;
    if (in_ready !== 1'b1 || c !== r[1]) begin
      errors++;
      $display("FAIL bp_drain1: got ir=%b C=%0h expected 1 %0h", in_ready, c, r[1]);
    end
    wait_cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || c !== r[2]) begin
      errors++;
      $display("FAIL bp_third: got ov=%b C=%0h expected 1 %0h", out_valid, c, r[2]);
    end
    wait_cycle();
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_empty: got ov=%b left=%0d expected 0 0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] cnt0;
    out_ready = 1'b0;
    a = 8'h55; b = 8'hFF; mode = 3'd2; in_valid = 1'b1;
    wait_cycle();
    out_ready = 1'b1;
    cnt0 = exp_cnt;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      mode = 3'($urandom_range(0, 7));
      wait_cycle();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got ir=%b ov=%b expected 1 1", i, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (op_count !== cnt0 + 4'd10) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected %0d", op_count, cnt0 + 4'd10);
    end
    wait_cycle();
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0 || op_count !== exp_cnt) begin
      errors++;
      $display("FAIL b2b_drain: got ov=%b left=%0d cnt=%0d expected 0 0 %0d",
               out_valid, exp_q.size(), op_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    a = 8'hFF; b = 8'h01; mode = 3'd1; in_valid = 1'b1;
    wait_cycle();
    a = 8'h12; mode = 3'd7;
    wait_cycle();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_fill: got ov=%b ir=%b expected 1 0", out_valid, in_ready);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 4'd0 || c !== 8'h00 || c_zero !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got ov=%b ir=%b cnt=%0d C=%0h cz=%b expected 0 1 0 0 0",
               out_valid, in_ready, op_count, c, c_zero);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 4'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_cycle();
      checks++;
      if (out_valid !== 1'b0 || op_count !== 4'd0) begin
        errors++;
        $display("FAIL mid_stale%0d: got ov=%b cnt=%0d expected 0 0", i, out_valid, op_count);
      end
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      mode = 3'($urandom_range(0, 7)); in_valid = 1'b1;
      wait_cycle();
    end
    in_valid = 1'b0;
    wait_cycle();
    checks++;
    if (op_count !== 4'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap: got cnt=%0d ov=%b expected 1 0", op_count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_width();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_gate_unit.md
LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the completed-operation counter width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port A, input, WIDTH: operand A.
REQ-007 Port B, input, WIDTH: operand B.
REQ-008 Port mode, input, 3: operation select, sampled together with A and B.
REQ-009 Port in_valid, input, 1: A/B/mode are valid this cycle.
REQ-010 Port in_ready, output, 1: the block can accept an operation this cycle.
REQ-011 Port C, output, WIDTH: result at the head of the output buffer.
REQ-012 Port C_zero, output, 1: high when C equals all zeros and out_valid is high.
REQ-013 Port out_valid, output, 1: C is valid.
REQ-014 Port out_ready, input, 1: the consumer takes C this cycle.
REQ-015 Port op_count, output, CNT_W: number of results consumed since reset.

Function
REQ-016 Input handshake: an operation SHALL be accepted on a rising edge where in_valid=1 and in_ready=1. Otherwise A, B and mode SHALL be ignored.
REQ-017 The mode encoding SHALL be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A (B ignored), 111 pass A.
REQ-018 Every operation SHALL be bitwise across all WIDTH bits, with no carries and no bit-to-bit interaction.
REQ-019 The result SHALL be computed from the values sampled at acceptance and written into a 2-entry FIFO output buffer on that same edge.
REQ-020 Latency: a result accepted at edge N SHALL be presented with out_valid=1 in the cycle after edge N when the buffer was empty.
REQ-021 Output handshake: the head entry SHALL be consumed on an edge where out_valid=1 and out_ready=1. Otherwise C SHALL hold stable while out_valid=1.
REQ-022 out_valid SHALL equal (occupancy != 0), and in_ready SHALL equal (occupancy != 2).
REQ-023 Neither in_ready nor out_valid SHALL depend combinationally on in_valid or out_ready.
REQ-024 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1, with the new result becoming the head after the old head leaves.
REQ-025 At occupancy 2, in_ready=0, so no push is possible even if a pop occurs on the same edge.
REQ-026 A pop at occupancy 0 is impossible because out_valid=0; out_ready SHALL be ignored.
REQ-027 Results SHALL leave the buffer in acceptance order.
REQ-028 When out_valid=0, C SHALL be all zeros and C_zero SHALL be 0.
REQ-029 op_count SHALL increment by 1 on every output handshake, wrapping from 2^CNT_W-1 to 0 with no saturation and no flag.
REQ-030 Read and write pointers SHALL be 1-bit and wrap 1->0.

Reset
REQ-031 While rst=1, regardless of clk, the following SHALL hold: occupancy 0, both pointers 0, out_valid=0, in_ready=1, C=0, C_zero=0, op_count=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered results without producing any output handshake.
REQ-033 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-034 Truth table, WIDTH=1, out_ready=1: all 8 modes x 4 operand pairs. Each yields the expected C one cycle after acceptance (e.g. AND 1,1 -> 1; NAND 1,1 -> 0; XNOR 0,1 -> 0).
REQ-035 Width, WIDTH=8: A=8'hF0, B=8'h3C. Expected C: AND -> 8'h30, OR -> 8'hFC, XOR -> 8'hCC, NOT A -> 8'h0F. AND of A=8'h0F with B=8'hF0 -> C=0 and C_zero=1.
REQ-036 Backpressure: out_ready=0, push 3 operations. After two acceptances in_ready=0 and the third is held. Raise out_ready: results drain in order and the third is then accepted.
REQ-037 Simultaneous push and pop at occupancy 1 for 10 cycles: in_ready and out_valid stay 1, op_count advances by 10, no results are lost or duplicated.
REQ-038 Reset mid-operation: with 2 entries buffered, pulse rst between clock edges. Immediately out_valid=0, in_ready=1, op_count=0, and no stale result appears afterwards.
REQ-039 Counter wrap, CNT_W=4: 17 consumed results -> op_count=1.
